fir_filter_mac: RTL
===================

# fir_filter_mac

Parametrised low-pass FIR filter with a time-multiplexed single multiply-accumulate engine and runtime-loadable signed coefficients. It replaces the fixed 8-tap, divide-based filter: one system clock with a sample-enable strobe, configurable data width, coefficient width and tap count, and rounding with saturation. It sits between the sine/accumulator sample source and the output register / DAC path.

## Interface
- DATA_W, 8, unsigned sample width for input and output
- COEF_W, 12, signed coefficient width, format Q1.(COEF_W-1), so FRAC = COEF_W-1
- TAPS, 8, filter length, range 2..64
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  single-cycle sample strobe
- filter_in  in  DATA_W  unsigned input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index
- coef_wdata  in  COEF_W  signed coefficient
- clr_ovr  in  1  clears the overrun flag
- filter_out  out  DATA_W  filtered sample, held between updates
- out_valid  out  1  one-cycle pulse when filter_out updates
- busy  out  1  high while a sample is being processed
- overrun  out  1  sticky flag: a sample was dropped

## Operation
- Delay line x[0..TAPS-1], x[0] newest; coefficient registers c[0..TAPS-1].
- FSM states: IDLE, MAC, DONE.
  - IDLE: when in_valid=1, shift filter_in into x[0], move x[k] to x[k+1], clear acc, set k=0, go to MAC.
  - MAC: acc += zero-extend(x[k]) * c[k] (signed); k++. After k=TAPS-1, go to DONE.
  - DONE: compute r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift). Saturate r to 0..2^DATA_W-1 and register it into filter_out. Pulse out_valid, go to IDLE.
- Widths:
  - Product is DATA_W+1+COEF_W bits.
  - acc is ACC_W = DATA_W+COEF_W+clog2(TAPS)+1 bits, signed. No internal overflow is possible.
- busy = 1 in MAC and DONE.
- in_valid while busy: the sample is dropped, the delay line is unchanged, and overrun is set.
- clr_ovr clears overrun. If a drop and clr_ovr occur in the same cycle, overrun is set (set wins).
- Coefficient writes:
  - Applied at the clock edge only when busy=0 and coef_addr < TAPS. Otherwise the write is ignored.
  - If coef_we and in_valid occur together in IDLE, both are accepted, and the MAC uses the newly written coefficient.
- Reset values:
  - filter_out=0, out_valid=0, busy=0, overrun=0.
  - Delay line all 0, acc=0, state IDLE.
  - c[0]=2^(COEF_W-1)-1, all other taps 0. This is a pass-through filter: output = input for all inputs below 2^(COEF_W-2).
- Reset asserted mid-operation aborts the computation immediately. No out_valid is produced and all state returns to the reset values above.

## Timing
- The accepting edge E0 is the edge where in_valid=1 in IDLE.
- The MAC runs on edges E1..E_TAPS. Edge E_TAPS+1 registers filter_out.
- out_valid is high for the cycle following E_TAPS+1. Latency is TAPS+1 clocks from the accepting edge.
- busy is high from after E0 until after E_TAPS+1. The FSM is in IDLE during the out_valid cycle, so a new in_valid in that cycle is accepted.
- Minimum sample spacing is TAPS+2 clocks (10 at default). With 100 MHz clk and a 10 kHz strobe there is ample margin.
- filter_out changes only at the edge that raises out_valid.

## Test plan
- Pass-through after reset: release reset, then apply strobes with filter_in = 37, 200, 255 spaced 20 clks apart. Required response: filter_out = 37, 200, 255, each with out_valid exactly 9 clks after its accepting edge.
- Impulse response: write c=[1024,512,256,0,0,0,0,0], then feed 200 followed by zeros. Required response: outputs 100, 50, 25, 0, 0.
- Saturation:
  - Set all c=2047 and feed constant 255. From the 8th output onward, filter_out = 255 (raw value ≈2039 clamps).
  - Set c[0]=-2048 and feed 100. Required response: filter_out = 0.
- Overrun: strobe in_valid 3 clks after an accepted sample. The second sample is dropped (delay line unchanged), overrun=1, and only one out_valid is produced. Then assert clr_ovr and check overrun=0.
- Coefficient guarding:
  - coef_we while busy leaves the coefficient unchanged.
  - coef_addr ≥ TAPS (with TAPS=6 build) is ignored.
  - coef_we and in_valid in the same IDLE cycle: the new coefficient is used in that same output.
- Reset mid-MAC: assert reset_n=0 at E3. All outputs read 0 immediately and no out_valid appears. After release, the pass-through behaviour of the first test is restored.

Source files
------------

// File: rtl/fir_filter_mac_if.sv
// Sample, coefficient-load and status bundle between the sample source and
// fir_filter_mac. The master drives samples and coefficients; the filter is the slave.
interface fir_filter_mac_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 12,
  parameter int TAPS   = 8
);
  localparam int ADDR_W = $clog2(TAPS);

  logic                     in_valid;
  logic [DATA_W-1:0]        filter_in;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     clr_ovr;
  logic [DATA_W-1:0]        filter_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output in_valid, filter_in, coef_we, coef_addr, coef_wdata, clr_ovr,
    input  filter_out, out_valid, busy, overrun
  );

  modport slave (
    input  in_valid, filter_in, coef_we, coef_addr, coef_wdata, clr_ovr,
    output filter_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/fir_filter_mac.sv
// Low-pass FIR with one time-multiplexed signed MAC: one tap per clock, then a
// round-half-up / saturate step into an unsigned DATA_W output register.
module fir_filter_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 12,
  parameter int TAPS   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  fir_filter_mac_if.slave bus
);
  localparam int ADDR_W = $clog2(TAPS);
  localparam int FRAC   = COEF_W - 1;
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] C_UNITY = {1'b0, {(COEF_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     ovalid_q, ovalid_d;
  logic                     ovr_q;
  logic [DATA_W-1:0]        x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];

  logic signed [PROD_W-1:0] xs, cs, prod;
  logic                     accept, addr_ok;

  function automatic logic signed [ACC_W-1:0] round_frac(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] half;
    half = '0;
    half[FRAC-1] = 1'b1;
    return (a + half) >>> FRAC;
  endfunction

  function automatic logic [DATA_W-1:0] sat_u(input logic signed [ACC_W-1:0] r);
    if (r[ACC_W-1])
      return '0;
    else if (|r[ACC_W-2:DATA_W])
      return '1;
    else
      return r[DATA_W-1:0];
  endfunction

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign addr_ok = ({1'b0, bus.coef_addr} < (ADDR_W+1)'(TAPS));

  // Samples are unsigned: zero-extend so the signed product keeps them positive.
  always_comb begin
    xs   = {{(COEF_W+1){1'b0}}, x_q[k_q]};
    cs   = {{(DATA_W+1){c_q[k_q][COEF_W-1]}}, c_q[k_q]};
    prod = xs * cs;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    out_d    = out_q;
    ovalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        k_d   = k_q + 1'b1;
        if (k_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        out_d    = sat_u(round_frac(acc_q));
        ovalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Set wins over clear when a drop and clr_ovr coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovr_q <= 1'b0;
    else if (bus.in_valid && (state_q != IDLE))
      ovr_q <= 1'b1;
    else if (bus.clr_ovr)
      ovr_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++)
        x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= bus.filter_in;
      for (int i = 1; i < TAPS; i++)
        x_q[i] <= x_q[i-1];
    end
  end

  // Writes are only taken in IDLE, so a running MAC never sees a coefficient change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++)
        c_q[i] <= (i == 0) ? C_UNITY : '0;
    end else if (bus.coef_we && (state_q == IDLE) && addr_ok) begin
      c_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign bus.filter_out = out_q;
  assign bus.out_valid  = ovalid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = ovr_q;
endmodule
